// File: rtl/uart_pkg.sv
// Shared UART constants and helpers, common to uart_rx and uart_tx.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Expected parity bit; narrower words are zero-extended by the caller.
  function automatic logic calc_parity(input logic [8:0] data, input int ptype);
    return (^data) ^ (ptype == PARITY_ODD);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Received-word valid/ready handshake between uart_rx and its consumer.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] data_out;
  logic                 valid;
  logic                 ready;

  modport master (output data_out, output valid, input ready);
  modport slave  (input data_out, input valid, output ready);
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser; early_o is the first stage, i.e. q_o one cycle ahead.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic early_o
);

  logic s1_q;
  logic s2_q;

  // Synchroniser chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o     = s2_q;
  assign early_o = s1_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling, parity/stop checks, valid/ready output.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 vote around each mid-bit sample.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV    = 434,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_TYPE = 1,
  parameter int STOP_BIT    = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx,
  uart_rx_if.master out_if,
  output logic      parity_err,
  output logic      frame_err,
  output logic      overrun,
  output logic      busy
);

  localparam logic [15:0] MID_C     = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] WRAP_C    = 16'(BAUD_DIV - 1);
  localparam logic [3:0]  LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic        LAST_STOP = 1'(STOP_BIT - 1);

  logic                 rx_s;
  logic                 rx_early_s;
  logic                 bit_s;
  logic                 strobe_s;
  logic                 start_s;
  logic                 par_bad_s;
  logic                 load_s;

  uart_state_e          state_q;
  logic [15:0]          cnt_q;
  logic [3:0]           bit_idx_q;
  logic                 stop_idx_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 par_q;
  logic                 fe_q;
  logic                 done_q;
  logic                 rx_prev_q;
  logic [1:0]           settle_q;
  logic                 busy_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 perr_q;
  logic                 ferr_q;
  logic                 ovr_q;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .d_i     (rx),
    .q_o     (rx_s),
    .early_o (rx_early_s)
  );

`ifdef UART_RX_MAJORITY_EN
  logic samp_q;

  // Holds the mid-1 sample; mid+1 is already sitting in the first sync stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q <= 1'b1;
    end else if (cnt_q == MID_C - 16'd1) begin
      samp_q <= rx_s;
    end else begin
      samp_q <= samp_q;
    end
  end

  assign bit_s = maj3(samp_q, rx_s, rx_early_s);
`else
  logic sync_unused_s;
  assign sync_unused_s = rx_early_s;
  assign bit_s         = rx_s;
`endif

  assign strobe_s = (cnt_q == MID_C);
  // The synchroniser's reset value is not a real line level, so edges are ignored until it flushes.
  assign start_s  = (settle_q == 2'd3) && rx_prev_q && !rx_s;

  // Completion decision.
  always_comb begin
    par_bad_s = 1'b0;
    load_s    = 1'b0;
    if (PARITY_TYPE != PARITY_NONE) begin
      par_bad_s = (par_q != calc_parity(9'(shreg_q), PARITY_TYPE));
    end else begin
      par_bad_s = 1'b0;
    end
    if (done_q && !fe_q && !par_bad_s && (!valid_q || out_if.ready)) begin
      load_s = 1'b1;
    end else begin
      load_s = 1'b0;
    end
  end

  // Receive state machine and bit timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 16'd0;
      bit_idx_q  <= 4'd0;
      stop_idx_q <= 1'b0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      fe_q       <= 1'b0;
      done_q     <= 1'b0;
      rx_prev_q  <= 1'b1;
      settle_q   <= 2'd0;
      busy_q     <= 1'b0;
    end else begin
      rx_prev_q <= rx_s;
      done_q    <= 1'b0;
      if (settle_q != 2'd3) begin
        settle_q <= settle_q + 2'd1;
      end
      if (state_q == ST_IDLE || cnt_q == WRAP_C) begin
        cnt_q <= 16'd0;
      end else begin
        cnt_q <= cnt_q + 16'd1;
      end

      case (state_q)
        ST_IDLE: begin
          if (start_s) begin
            state_q <= ST_START;
            busy_q  <= 1'b1;
            fe_q    <= 1'b0;
          end
        end
        ST_START: begin
          if (strobe_s) begin
            if (!bit_s) begin
              state_q   <= ST_DATA;
              bit_idx_q <= 4'd0;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (strobe_s) begin
            shreg_q   <= {bit_s, shreg_q[DATA_BITS-1:1]};
            bit_idx_q <= bit_idx_q + 4'd1;
            if (bit_idx_q == LAST_BIT) begin
              state_q    <= (PARITY_TYPE != PARITY_NONE) ? ST_PARITY : ST_STOP;
              stop_idx_q <= 1'b0;
            end
          end
        end
        ST_PARITY: begin
          if (strobe_s) begin
            par_q   <= bit_s;
            state_q <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (strobe_s) begin
            fe_q       <= fe_q | !bit_s;
            stop_idx_q <= stop_idx_q + 1'b1;
            if (stop_idx_q == LAST_STOP) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Output word, handshake and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ferr_q <= done_q && fe_q;
      perr_q <= done_q && !fe_q && par_bad_s;
      ovr_q  <= done_q && !fe_q && !par_bad_s && valid_q && !out_if.ready;
      if (load_s) begin
        data_q  <= shreg_q;
        valid_q <= 1'b1;
      end else if (valid_q && out_if.ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_if.data_out = data_q;
  assign out_if.valid    = valid_q;
  assign parity_err      = perr_q;
  assign frame_err       = ferr_q;
  assign overrun         = ovr_q;
  assign busy            = busy_q;

endmodule
